// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit computer control unit: control-word bit map,
// opcode map, microstep encoding and the run/halt state type.
package cpu_ctrl_pkg;

  localparam int CW_WIDTH  = 24;
  localparam int NUM_STEPS = 5;
  localparam int STEP_W    = 3;

  typedef logic [STEP_W-1:0] step_t;

  localparam step_t STEP_T0   = step_t'(0);
  localparam step_t STEP_T1   = step_t'(1);
  localparam step_t STEP_T2   = step_t'(2);
  localparam step_t STEP_T3   = step_t'(3);
  localparam step_t STEP_T4   = step_t'(4);
  localparam step_t STEP_LAST = step_t'(NUM_STEPS - 1);

  localparam int CW_HLT  = 0;
  localparam int CW_MI   = 1;
  localparam int CW_RI   = 2;
  localparam int CW_RO   = 3;
  localparam int CW_IO   = 4;
  localparam int CW_II   = 5;
  localparam int CW_REGI = 6;
  localparam int CW_REGO = 7;
  localparam int CW_EO   = 8;
  localparam int CW_SU   = 9;
  localparam int CW_BI   = 10;
  localparam int CW_OI   = 11;
  localparam int CW_CE   = 12;
  localparam int CW_CO   = 13;
  localparam int CW_J    = 14;
  localparam int CW_FI   = 15;
  // Extension bits, reserved for a larger ISA and never asserted by the base ROM
  localparam int CW_IOM  = 16;
  localparam int CW_IIM  = 17;
  localparam int CW_IOA  = 18;
  localparam int CW_IIA  = 19;
  localparam int CW_XI   = 20;
  localparam int CW_SPJ  = 21;
  localparam int CW_BPI  = 22;
  localparam int CW_BPO  = 23;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {ST_RUN, ST_HALT} seq_state_t;

  function automatic logic [CW_WIDTH-1:0] cw_bit(input int idx);
    return CW_WIDTH'(1) << idx;
  endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// Bus between the IR/flags registers, the sequencer and the control-signal fan-out.
interface microcode_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic                en;
  logic [3:0]          opcode;
  logic                flag_c;
  logic                flag_z;
  logic [CW_WIDTH-1:0] control_word;
  step_t               step;
  logic                halted;
  logic                instr_done;

  modport master (
    output en, opcode, flag_c, flag_z,
    input  control_word, step, halted, instr_done
  );

  modport slave (
    input  en, opcode, flag_c, flag_z,
    output control_word, step, halted, instr_done
  );
endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode store: (opcode, step, flags) -> raw control word.
module microcode_rom import cpu_ctrl_pkg::*; (
  input  logic [3:0]          opcode,
  input  step_t               step,
  input  logic                flag_c,
  input  logic                flag_z,
  output logic [CW_WIDTH-1:0] word
);

  logic [CW_WIDTH-1:0] t2, t3, t4, raw, reserved;

  assign reserved = cw_bit(CW_IOM) | cw_bit(CW_IIM) | cw_bit(CW_IOA) | cw_bit(CW_IIA) |
                    cw_bit(CW_XI)  | cw_bit(CW_SPJ) | cw_bit(CW_BPI) | cw_bit(CW_BPO);

  // Execute-phase words per opcode; untaken conditional jumps fall to an all-zero word
  always_comb begin
    t2 = '0;
    t3 = '0;
    t4 = '0;
    case (opcode)
      OP_LDA: begin
        t2 = cw_bit(CW_IO) | cw_bit(CW_MI);
        t3 = cw_bit(CW_RO) | cw_bit(CW_REGI);
      end
      OP_ADD: begin
        t2 = cw_bit(CW_IO) | cw_bit(CW_MI);
        t3 = cw_bit(CW_RO) | cw_bit(CW_BI);
        t4 = cw_bit(CW_EO) | cw_bit(CW_REGI) | cw_bit(CW_FI);
      end
      OP_SUB: begin
        t2 = cw_bit(CW_IO) | cw_bit(CW_MI);
        t3 = cw_bit(CW_RO) | cw_bit(CW_BI);
        t4 = cw_bit(CW_EO) | cw_bit(CW_REGI) | cw_bit(CW_SU) | cw_bit(CW_FI);
      end
      OP_STA: begin
        t2 = cw_bit(CW_IO) | cw_bit(CW_MI);
        t3 = cw_bit(CW_REGO) | cw_bit(CW_RI);
      end
      OP_LDI: t2 = cw_bit(CW_IO) | cw_bit(CW_REGI);
      OP_JMP: t2 = cw_bit(CW_IO) | cw_bit(CW_J);
      OP_JC:  t2 = flag_c ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
      OP_JZ:  t2 = flag_z ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
      OP_OUT: t2 = cw_bit(CW_REGO) | cw_bit(CW_OI);
      OP_HLT: t2 = cw_bit(CW_HLT);
      default: ;
    endcase
  end

  always_comb begin
    raw = '0;
    case (step)
      STEP_T0: raw = cw_bit(CW_CO) | cw_bit(CW_MI);
      STEP_T1: raw = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
      STEP_T2: raw = t2;
      STEP_T3: raw = t3;
      STEP_T4: raw = t4;
      default: raw = '0;
    endcase
  end

  assign word = raw & ~reserved;

endmodule

// File: rtl/microcode_sequencer.sv
// Control unit: owns the microstep counter and sticky halt, gates the ROM word onto the bus.
module microcode_sequencer import cpu_ctrl_pkg::*; (
  input logic                  clk,
  input logic                  reset,
  microcode_sequencer_if.slave bus
);

  seq_state_t          state, state_n;
  step_t               step_q, step_n;
  logic [CW_WIDTH-1:0] raw_word;
  logic                live;
  logic                wrap;

  microcode_rom u_rom (
    .opcode (bus.opcode),
    .step   (step_q),
    .flag_c (bus.flag_c),
    .flag_z (bus.flag_z),
    .word   (raw_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      step_q <= STEP_T0;
    end else begin
      state  <= state_n;
      step_q <= step_n;
    end
  end

  // An empty execute word is a dead cycle, so short instructions wrap early
  always_comb begin
    state_n = state;
    step_n  = step_q;
    live    = bus.en && (state == ST_RUN) && !reset;
    wrap    = ((step_q >= STEP_T2) && (raw_word == '0)) || (step_q == STEP_LAST);
    if (live) begin
      if (raw_word[CW_HLT]) begin
        state_n = ST_HALT;
      end else if (wrap) begin
        step_n = STEP_T0;
      end else begin
        step_n = step_q + step_t'(1);
      end
    end
  end

  assign bus.control_word = live ? raw_word : '0;
  assign bus.instr_done   = live && wrap;
  assign bus.step         = step_q;
  assign bus.halted       = (state == ST_HALT);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench: directed instruction sequences plus randomized traffic against an ISA-level model.
module tb_microcode_sequencer;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  microcode_sequencer_if bus();

  microcode_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          num_vectors = 0;
  int          num_miscompares = 0;
  int          m_step = 0;
  bit          m_halted = 1'b0;
  logic [23:0] exec_tab [16][3];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_vectors++;
    if (actual !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  // ISA-level view: fixed fetch words, then a per-opcode table of T2/T3/T4 words
  function automatic logic [23:0] modelWord(input logic [3:0] op, input int st, input bit c, input bit z);
    logic [23:0] w;
    if (st == 0) return 24'h002002;
    if (st == 1) return 24'h001028;
    if (st > 4) return 24'h0;
    w = exec_tab[op][st-2];
    if (op == 4'h7 && !c) w = 24'h0;
    if (op == 4'h8 && !z) w = 24'h0;
    return w;
  endfunction

  task automatic applyStimulus(input bit e, input logic [3:0] op, input bit c, input bit z);
    logic [23:0] w;
    bit live, done;
    @(negedge clk);
    bus.en = e;
    bus.opcode = op;
    bus.flag_c = c;
    bus.flag_z = z;
    #1;
    w    = modelWord(op, m_step, c, z);
    live = e && !m_halted;
    done = live && ((m_step >= 2 && w == 24'h0) || m_step == 4);
    checkOutput("control_word", 32'(bus.control_word), live ? 32'(w) : 32'h0);
    checkOutput("step", 32'(bus.step), 32'(m_step));
    checkOutput("halted", 32'(bus.halted), 32'(m_halted));
    checkOutput("instr_done", 32'(bus.instr_done), 32'(done));
    if (live) begin
      if (w[0]) m_halted = 1'b1;
      else if (done) m_step = 0;
      else m_step++;
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2;
    bus.en = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("rst_control_word", 32'(bus.control_word), 32'h0);
    checkOutput("rst_step", 32'(bus.step), 32'h0);
    checkOutput("rst_halted", 32'(bus.halted), 32'h0);
    checkOutput("rst_instr_done", 32'(bus.instr_done), 32'h0);
    m_step = 0;
    m_halted = 1'b0;
    @(negedge clk);
    #3;
    bus.en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic runInstr(input logic [3:0] op, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, op, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    logic [3:0] op;
    int halt_cycles;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 3; j++) exec_tab[i][j] = 24'h0;
    exec_tab[1]  = '{24'h000012, 24'h000048, 24'h000000};
    exec_tab[2]  = '{24'h000012, 24'h000408, 24'h008140};
    exec_tab[3]  = '{24'h000012, 24'h000408, 24'h008340};
    exec_tab[4]  = '{24'h000012, 24'h000084, 24'h000000};
    exec_tab[5]  = '{24'h000050, 24'h000000, 24'h000000};
    exec_tab[6]  = '{24'h004010, 24'h000000, 24'h000000};
    exec_tab[7]  = '{24'h004010, 24'h000000, 24'h000000};
    exec_tab[8]  = '{24'h004010, 24'h000000, 24'h000000};
    exec_tab[14] = '{24'h000880, 24'h000000, 24'h000000};
    exec_tab[15] = '{24'h000001, 24'h000000, 24'h000000};

    bus.en = 1'b0;
    bus.opcode = 4'h0;
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;
    pulseReset();

    $display("[TB] LDA, ADD, SUB full instructions");
    runInstr(4'h1, 6);
    runInstr(4'h2, 5);
    runInstr(4'h3, 6);

    $display("[TB] JC untaken then taken");
    runInstr(4'h7, 2);
    applyStimulus(1'b1, 4'h7, 1'b0, 1'($urandom));
    runInstr(4'h7, 2);
    applyStimulus(1'b1, 4'h7, 1'b1, 1'($urandom));
    runInstr(4'h7, 2);

    $display("[TB] LDA stalled at T3");
    runInstr(4'h1, 3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h1, 1'($urandom), 1'($urandom));
    runInstr(4'h1, 3);

    $display("[TB] HLT then reset");
    runInstr(4'hF, 3);
    for (int i = 0; i < 10; i++) applyStimulus(1'(i % 2), 4'($urandom), 1'($urandom), 1'($urandom));
    pulseReset();

    $display("[TB] reset in T3 of ADD");
    runInstr(4'h2, 3);
    pulseReset();
    runInstr(4'h2, 2);

    $display("[TB] randomized traffic");
    op = 4'h1;
    halt_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_halted) begin
        halt_cycles++;
        if (halt_cycles > 4) begin
          pulseReset();
          halt_cycles = 0;
        end
      end
      if (m_step == 0) begin
        op = 4'($urandom_range(15));
        if (op == 4'hF && $urandom_range(3) != 0) op = 4'h2;
      end
      applyStimulus($urandom_range(9) != 0, op, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule
